// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
// Shared definitions for the single-port byte-enable RAM.
//   RAM_WRITE_FIRST / RAM_READ_FIRST / RAM_NO_CHANGE : values for MODE
//   clr_state_e : state of the optional power-up clear sequencer
// ---------------------------------------------------------------------------
package ram_pkg;

  localparam int RAM_WRITE_FIRST = 0;
  localparam int RAM_READ_FIRST  = 1;
  localparam int RAM_NO_CHANGE   = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_e;

endpackage

// File: rtl/rams_sp_out_pipe.sv
// ---------------------------------------------------------------------------
// rams_sp_out_pipe
// LATENCY-1 output register stages behind the RAM array register. Valid bits
// shift every cycle; each data stage loads only when its incoming valid is set
// and holds otherwise, so the output keeps the last valid word.
// Ports:
//   clk, rstn        clock, async active-low reset
//   i_data, i_vld    word and valid from the array register
//   o_data, o_vld    delayed word and valid (pass-through when LATENCY==1)
// ---------------------------------------------------------------------------
module rams_sp_out_pipe #(
  parameter int WIDTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_vld,
  output logic [WIDTH-1:0] o_data,
  output logic             o_vld
);

  if (LATENCY == 1) begin : g_bypass
    // Clock and reset have no loads in this configuration.
    logic w_unused;
    assign w_unused = clk ^ rstn;
    assign o_data   = i_data;
    assign o_vld    = i_vld;
  end else begin : g_pipe
    logic [WIDTH-1:0]   r_data_p [LATENCY-1];
    logic [LATENCY-2:0] r_vld_p;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_vld_p <= '0;
        for (int s = 0; s < LATENCY - 1; s++) r_data_p[s] <= '0;
      end else begin
        // stage p1: first output register
        r_vld_p[0] <= i_vld;
        if (i_vld) r_data_p[0] <= i_data;
        // stages p2..: further output registers
        for (int s = 1; s < LATENCY - 1; s++) begin
          r_vld_p[s] <= r_vld_p[s-1];
          if (r_vld_p[s-1]) r_data_p[s] <= r_data_p[s-1];
        end
      end
    end

    assign o_data = r_data_p[LATENCY-2];
    assign o_vld  = r_vld_p[LATENCY-2];
  end

endmodule

// File: rtl/rams_sp_be_pipe.sv
// ---------------------------------------------------------------------------
// rams_sp_be_pipe
// Single-port block RAM with per-byte-lane write enables, selectable write
// mode (write-first / read-first / no-change) and a 1..3 cycle registered
// read path with valid tracking. Used as on-chip staging buffer.
// Optional feature macro: RAMS_SP_CLEAR_EN -- after reset release the array
// is zeroed one word per cycle (busy high for DEPTH cycles) before accepting
// accesses. Without it, busy is tied low and contents are undefined.
// Ports:
//   clk, rstn       clock, async active-low reset
//   en              access enable (accepted when en && !busy)
//   we              per-lane write enables, any bit set = write access
//   addr, di        word address, write data
//   dout, dout_valid read data and its valid, LATENCY cycles after accept
//   busy            accesses ignored while high
// ---------------------------------------------------------------------------
module rams_sp_be_pipe
  import ram_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int BYTE_W     = 8,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int MODE       = 0,
  parameter int LATENCY    = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  input  logic [WIDTH/BYTE_W-1:0]   we,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [WIDTH-1:0]          di,
  output logic [WIDTH-1:0]          dout,
  output logic                      dout_valid,
  output logic                      busy
);

  localparam int LANES = WIDTH / BYTE_W;

  if (LATENCY < 1 || LATENCY > 3) begin : g_bad_latency
    $error("rams_sp_be_pipe: LATENCY must be 1..3");
  end
  if (WIDTH % BYTE_W != 0) begin : g_bad_width
    $error("rams_sp_be_pipe: WIDTH must be a multiple of BYTE_W");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_busy;
  logic             w_acc;
  logic             w_issue;
  logic [WIDTH-1:0] w_old;
  logic [WIDTH-1:0] w_merged;
  logic [WIDTH-1:0] w_rd;
  logic [WIDTH-1:0] r_dout_p0;
  logic             r_vld_p0;

  assign w_acc = en & ~w_busy;
  assign w_old = r_mem[addr];

  // Word as it looks after this access: written lanes replaced, others kept.
  always_comb begin
    w_merged = w_old;
    for (int l = 0; l < LANES; l++) begin
      if (we[l]) w_merged[l*BYTE_W +: BYTE_W] = di[l*BYTE_W +: BYTE_W];
    end
  end

  // For pure reads w_merged equals w_old, so the mode only matters on writes.
  assign w_rd    = (MODE == RAM_READ_FIRST) ? w_old : w_merged;
  assign w_issue = w_acc & ~((MODE == RAM_NO_CHANGE) & (|we));

`ifdef RAMS_SP_CLEAR_EN
  clr_state_e             r_state;
  clr_state_e             w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_clr_addr;
  logic [ADDR_WIDTH-1:0]  w_clr_addr_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    case (r_state)
      ST_CLEAR: begin
        if (r_clr_addr == ADDR_WIDTH'(DEPTH - 1)) w_state_nxt = ST_READY;
        else w_clr_addr_nxt = r_clr_addr + ADDR_WIDTH'(1);
      end
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_READY;
    endcase
  end

  assign w_busy = (r_state == ST_CLEAR);
`else
  assign w_busy = 1'b0;
`endif

  // Array: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
`ifdef RAMS_SP_CLEAR_EN
    if (w_busy) begin
      r_mem[r_clr_addr] <= '0;
    end else
`endif
    if (w_acc) begin
      for (int l = 0; l < LANES; l++) begin
        if (we[l]) r_mem[addr][l*BYTE_W +: BYTE_W] <= di[l*BYTE_W +: BYTE_W];
      end
    end
  end

  // stage p0: array output register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld_p0  <= 1'b0;
      r_dout_p0 <= '0;
    end else begin
      r_vld_p0 <= w_issue;
      if (w_issue) r_dout_p0 <= w_rd;
    end
  end

  rams_sp_out_pipe #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_out_pipe (
    .clk    (clk),
    .rstn   (rstn),
    .i_data (r_dout_p0),
    .i_vld  (r_vld_p0),
    .o_data (dout),
    .o_vld  (dout_valid)
  );

  assign busy = w_busy;

endmodule

// File: tb/tb_rams_sp_be_pipe.sv
// ---------------------------------------------------------------------------
// tb_rams_sp_be_pipe
// Three RAM instances share one stimulus stream: write-first/latency 1,
// read-first/latency 2, no-change/latency 3 (32-bit words, 8-bit lanes,
// 16 words). A reference model keeps the memory contents as a plain array
// and, per instance, a history of issued results delayed by the latency.
// ---------------------------------------------------------------------------
module tb_rams_sp_be_pipe;

  localparam int DW  = 32;
  localparam int DEP = 16;
  localparam int AW  = 4;
  localparam int NI  = 3;
  localparam int LATS  [NI] = '{1, 2, 3};
  localparam int MODES [NI] = '{0, 1, 2};

  logic          clk;
  logic          rstn;
  logic          en;
  logic [3:0]    we;
  logic [AW-1:0] addr;
  logic [DW-1:0] di;
  logic [DW-1:0] dout_a [NI];
  logic          vld_a  [NI];
  logic          busy_a [NI];

  rams_sp_be_pipe #(.WIDTH(DW), .BYTE_W(8), .DEPTH(DEP), .ADDR_WIDTH(AW), .MODE(0), .LATENCY(1)) u_wf (
    .clk(clk), .rstn(rstn), .en(en), .we(we), .addr(addr), .di(di),
    .dout(dout_a[0]), .dout_valid(vld_a[0]), .busy(busy_a[0]));
  rams_sp_be_pipe #(.WIDTH(DW), .BYTE_W(8), .DEPTH(DEP), .ADDR_WIDTH(AW), .MODE(1), .LATENCY(2)) u_rf (
    .clk(clk), .rstn(rstn), .en(en), .we(we), .addr(addr), .di(di),
    .dout(dout_a[1]), .dout_valid(vld_a[1]), .busy(busy_a[1]));
  rams_sp_be_pipe #(.WIDTH(DW), .BYTE_W(8), .DEPTH(DEP), .ADDR_WIDTH(AW), .MODE(2), .LATENCY(3)) u_nc (
    .clk(clk), .rstn(rstn), .en(en), .we(we), .addr(addr), .di(di),
    .dout(dout_a[2]), .dout_valid(vld_a[2]), .busy(busy_a[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model state
  logic [DW-1:0] m [DEP];
  bit            iss_h [NI][4096];
  logic [DW-1:0] res_h [NI][4096];
  logic [DW-1:0] hold  [NI];
  int            cyc;
  int            clr_left;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int clear_depth();
`ifdef RAMS_SP_CLEAR_EN
    return DEP;
`else
    return 0;
`endif
  endfunction

  // One clock: drive inputs, take the edge, update model, compare outputs.
  task automatic step(input bit e, input logic [3:0] w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] old_w, new_w;
    bit            acc;
    int            src;
    en = e; we = w; addr = a; di = d;
    @(posedge clk); #1;
    acc = e && (clr_left == 0);
    if (clr_left > 0) begin
      m[DEP - clr_left] = '0;
      clr_left--;
    end
    old_w = m[a];
    new_w = old_w;
    for (int l = 0; l < 4; l++) if (w[l]) new_w[l*8 +: 8] = d[l*8 +: 8];
    if (acc) m[a] = new_w;
    for (int k = 0; k < NI; k++) begin
      iss_h[k][cyc] = acc && !(MODES[k] == 2 && w != 4'h0);
      res_h[k][cyc] = (MODES[k] == 1) ? old_w : new_w;
    end
    for (int k = 0; k < NI; k++) begin
      bit ev;
      src = cyc - (LATS[k] - 1);
      ev  = (src >= 0) ? iss_h[k][src] : 1'b0;
      if (ev) hold[k] = res_h[k][src];
      chk($sformatf("valid[%0d]@%0d", k, cyc), {31'b0, vld_a[k]}, {31'b0, ev});
      chk($sformatf("dout[%0d]@%0d", k, cyc), dout_a[k], hold[k]);
      chk($sformatf("busy[%0d]@%0d", k, cyc), {31'b0, busy_a[k]}, {31'b0, clr_left > 0});
    end
    cyc++;
  endtask

  task automatic check_in_reset(input string tag);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s_valid[%0d]", tag, k), {31'b0, vld_a[k]}, 32'd0);
      chk($sformatf("%s_dout[%0d]", tag, k), dout_a[k], 32'd0);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rstn     = 1'b1;
    cyc      = 0;
    clr_left = clear_depth();
    for (int k = 0; k < NI; k++) hold[k] = '0;
  endtask

  task automatic random_steps(input int n);
    for (int i = 0; i < n; i++) begin
      logic [3:0] w;
      w = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) w = 4'h0;
      step($urandom_range(0, 3) != 0, w, AW'($urandom_range(0, DEP - 1)), $urandom);
    end
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; we = '0; addr = '0; di = '0;
    cyc = 0; clr_left = 0;
    for (int k = 0; k < NI; k++) hold[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_in_reset("reset");
    release_reset();

    // Clear phase (only when the feature is built in): en is ignored.
    while (clr_left > 0) step(1'b1, 4'hF, AW'($urandom_range(0, DEP - 1)), $urandom);
`ifdef RAMS_SP_CLEAR_EN
    for (int a = 0; a < DEP; a++) step(1'b1, 4'h0, AW'(a), '0);
    repeat (3) step(1'b0, 4'h0, '0, '0);
`endif

    // Give every word a defined value.
    for (int a = 0; a < DEP; a++) step(1'b1, 4'hF, AW'(a), $urandom);

    // Write-first, full and partial lane writes.
    step(1'b1, 4'hF, 4'd5, 32'hDEADBEEF);
    chk("wf_full", dout_a[0], 32'hDEADBEEF);
    step(1'b1, 4'h1, 4'd5, 32'h000000AA);
    chk("wf_lane0", dout_a[0], 32'hDEADBEAA);

    // Read-first: old word on the write, new word on the following read.
    step(1'b1, 4'hF, 4'd7, 32'h11111111);
    step(1'b1, 4'hF, 4'd7, 32'h22222222);
    step(1'b1, 4'h0, 4'd7, 32'h0);
    chk("rf_old", dout_a[1], 32'h11111111);
    step(1'b0, 4'h0, 4'd0, 32'h0);
    chk("rf_new", dout_a[1], 32'h22222222);

    // No-change: read 0x33 then write; write issues nothing, dout holds.
    step(1'b1, 4'hF, 4'd3, 32'h00000033);
    step(1'b1, 4'h0, 4'd3, 32'h0);
    step(1'b1, 4'hF, 4'd3, 32'h00000044);
    step(1'b0, 4'h0, 4'd0, 32'h0);
    chk("nc_read", dout_a[2], 32'h00000033);
    chk("nc_read_v", {31'b0, vld_a[2]}, 32'd1);
    step(1'b0, 4'h0, 4'd0, 32'h0);
    chk("nc_write_v", {31'b0, vld_a[2]}, 32'd0);
    chk("nc_hold", dout_a[2], 32'h00000033);

    // Back-to-back reads, then reads with enable gaps.
    step(1'b1, 4'h0, 4'd0, 32'h0);
    step(1'b1, 4'h0, 4'd1, 32'h0);
    step(1'b1, 4'h0, 4'd2, 32'h0);
    step(1'b0, 4'h0, 4'd0, 32'h0);
    step(1'b1, 4'h0, 4'd5, 32'h0);
    step(1'b0, 4'h0, 4'd0, 32'h0);
    step(1'b1, 4'h0, 4'd7, 32'h0);
    repeat (3) step(1'b0, 4'h0, 4'd0, 32'h0);

    random_steps(300);

    // Reset in the middle of a busy stream.
    random_steps(5);
    step(1'b1, 4'h0, 4'd5, 32'h0);
    step(1'b1, 4'h0, 4'd6, 32'h0);
    en = 1'b0; we = '0;
    #2 rstn = 1'b0;
    #1 check_in_reset("midrst");
    @(posedge clk); #1;
    check_in_reset("midrst_hold");
    release_reset();
    while (clr_left > 0) step(1'b1, 4'hF, AW'($urandom_range(0, DEP - 1)), $urandom);
    // Memory written before the reset is still present (model keeps it).
    for (int a = 0; a < DEP; a++) step(1'b1, 4'h0, AW'(a), '0);
    random_steps(150);
    repeat (3) step(1'b0, 4'h0, 4'd0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
